// File: rtl/gr_hist_pkg.sv
// gr_hist_pkg: shared types and constants for the gr_hist histogram block.
//   state_t    : acquisition state machine encoding
//   INC_LAT    : din_valid cycle to committed bin write (and done rising)
//   RD_LAT     : rd_req to rd_valid/rd_data
//   DEF_*      : default widths used by gr_hist
package gr_hist_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CLEAR = 2'd1,
        ACC   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int INC_LAT = 3;
    localparam int RD_LAT  = 2;

    localparam int DIN_W          = 12;
    localparam int DEF_BIN_BITS   = 6;
    localparam int DEF_SHIFT      = 6;
    localparam int DEF_CNT_W      = 16;
    localparam int DEF_NSAMP_W    = 20;

endpackage

// File: rtl/gr_hist_ram.sv
// gr_hist_ram: simple dual-port RAM, one write port and one registered read port.
//   clk   : clock
//   we    : write enable; waddr/wdata written on the rising edge
//   raddr : read address; rdata shows mem[raddr] one cycle later
// A read and a write to the same address on the same edge return the old data;
// the increment pipeline in gr_hist forwards around this.
module gr_hist_ram #(
    parameter int P_AW = 6,
    parameter int P_DW = 16
) (
    input  logic            clk,
    input  logic            we,
    input  logic [P_AW-1:0] waddr,
    input  logic [P_DW-1:0] wdata,
    input  logic [P_AW-1:0] raddr,
    output logic [P_DW-1:0] rdata
);

    logic [P_DW-1:0] mem [0:(1<<P_AW)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/gr_hist.sv
// gr_hist: histogram accumulator for 12-bit noise samples.
//   clk, rst          : clock, asynchronous active-high reset
//   din, din_valid    : sample input, binned as din >> P_SHIFT (clamped to top bin)
//   start, nsamp      : clear all bins, then accumulate nsamp samples
//   busy, done        : busy in CLEAR/ACC; done held from completion until next start
//   rd_req, rd_addr   : bin readout request (honoured in IDLE/DONE only)
//   rd_data, rd_valid : bin count, two cycles after rd_req; rd_data holds otherwise
module gr_hist
    import gr_hist_pkg::*;
#(
    parameter int P_BIN_BITS = DEF_BIN_BITS,
    parameter int P_SHIFT    = DEF_SHIFT,
    parameter int P_CNT_W    = DEF_CNT_W,
    parameter int P_NSAMP_W  = DEF_NSAMP_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DIN_W-1:0]      din,
    input  logic                  din_valid,
    input  logic                  start,
    input  logic [P_NSAMP_W-1:0]  nsamp,
    output logic                  busy,
    output logic                  done,
    input  logic                  rd_req,
    input  logic [P_BIN_BITS-1:0] rd_addr,
    output logic [P_CNT_W-1:0]    rd_data,
    output logic                  rd_valid
);

    localparam int NBINS = 1 << P_BIN_BITS;

    function automatic logic [P_BIN_BITS-1:0] bin_idx(input logic [DIN_W-1:0] d);
        logic [DIN_W-1:0] sh;
        sh = d >> P_SHIFT;
        if (sh > DIN_W'(NBINS - 1)) begin
            return '1;
        end else begin
            return sh[P_BIN_BITS-1:0];
        end
    endfunction

    function automatic logic [P_CNT_W-1:0] sat_inc(input logic [P_CNT_W-1:0] c);
        return (c == '1) ? c : c + 1'b1;
    endfunction

    state_t                 state, state_nx;
    logic [P_BIN_BITS-1:0]  clr_addr;
    logic [P_NSAMP_W-1:0]   nsamp_q;
    logic [P_NSAMP_W-1:0]   scnt;
    logic                   rd_grant;
    logic                   start_ok;

    logic                   acc_p0, last_p0;
    logic [P_BIN_BITS-1:0]  idx_p0;
    logic                   vld_p1, last_p1;
    logic [P_BIN_BITS-1:0]  idx_p1;
    logic [P_CNT_W-1:0]     base_p1;
    logic                   vld_p2, last_p2;
    logic [P_BIN_BITS-1:0]  idx_p2;
    logic [P_CNT_W-1:0]     cnt_p2;
    logic                   vld_p3;
    logic [P_BIN_BITS-1:0]  idx_p3;
    logic [P_CNT_W-1:0]     cnt_p3;
    logic                   rd_p1;

    logic                   ram_we;
    logic [P_BIN_BITS-1:0]  ram_waddr, ram_raddr;
    logic [P_CNT_W-1:0]     ram_wdata, ram_rdata;

    gr_hist_ram #(
        .P_AW (P_BIN_BITS),
        .P_DW (P_CNT_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .raddr (ram_raddr),
        .rdata (ram_rdata)
    );

    assign busy     = (state == CLEAR) || (state == ACC);
    assign done     = (state == DONE);
    assign rd_grant = (state == IDLE) || (state == DONE);
    assign start_ok = rd_grant && start;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE, DONE: if (start) state_nx = CLEAR;
            // nsamp=0 has nothing to accumulate, so skip straight past ACC
            CLEAR:      if (clr_addr == '1) state_nx = (nsamp_q == '0) ? DONE : ACC;
            ACC:        if (vld_p2 && last_p2) state_nx = DONE;
            default:    state_nx = IDLE;
        endcase
    end

    // Stage 0: accept sample, form bin index, issue RAM read
    always_comb begin
        acc_p0  = (state == ACC) && din_valid && (scnt != nsamp_q);
        last_p0 = acc_p0 && (scnt == nsamp_q - 1'b1);
        idx_p0  = bin_idx(din);

        // readout owns the read port whenever it may be granted
        ram_raddr = rd_grant ? rd_addr : idx_p0;

        ram_we    = vld_p2;
        ram_waddr = idx_p2;
        ram_wdata = cnt_p2;
        if (state == CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr;
            ram_wdata = '0;
        end
    end

    // Stage 1: read data returns; forward the two writes the RAM read missed
    always_comb begin
        base_p1 = ram_rdata;
        if (vld_p2 && (idx_p2 == idx_p1)) begin
            base_p1 = cnt_p2;
        end else if (vld_p3 && (idx_p3 == idx_p1)) begin
            base_p1 = cnt_p3;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            clr_addr <= '0;
            nsamp_q  <= '0;
            scnt     <= '0;
            vld_p1   <= 1'b0;
            last_p1  <= 1'b0;
            vld_p2   <= 1'b0;
            last_p2  <= 1'b0;
            vld_p3   <= 1'b0;
            rd_p1    <= 1'b0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
        end else begin
            state <= state_nx;
            if (start_ok) begin
                nsamp_q  <= nsamp;
                scnt     <= '0;
                clr_addr <= '0;
            end else if (state == CLEAR) begin
                clr_addr <= clr_addr + 1'b1;
            end
            if (acc_p0) begin
                scnt <= scnt + 1'b1;
            end
            vld_p1  <= acc_p0;
            last_p1 <= last_p0;
            vld_p2  <= vld_p1;
            last_p2 <= last_p1;
            vld_p3  <= vld_p2;
            // reads issued before a start still finish with pre-clear data
            rd_p1    <= rd_req && rd_grant;
            rd_valid <= rd_p1;
            if (rd_p1) begin
                rd_data <= ram_rdata;
            end
        end
    end

    // Stage 2: saturating increment registered, written to RAM this cycle
    always_ff @(posedge clk) begin
        idx_p1 <= idx_p0;
        idx_p2 <= idx_p1;
        cnt_p2 <= sat_inc(base_p1);
        idx_p3 <= idx_p2;
        cnt_p3 <= cnt_p2;
    end

endmodule

// File: tb/tb_gr_hist.sv
module tb_gr_hist;

    typedef struct packed {
        logic [11:0] din;
        logic        vld;
    } stim_t;

    typedef struct packed {
        logic [5:0]  addr;
        logic [15:0] cnt;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] din;
    logic        din_valid;
    logic        start;
    logic [19:0] nsamp;
    logic        rd_req;
    logic [5:0]  rd_addr;
    logic        busy_a, done_a, rd_valid_a;
    logic [15:0] rd_data_a;
    logic        busy_b, done_b, rd_valid_b;
    logic [3:0]  rd_data_b;

    int n_pass = 0;
    int n_tot  = 0;
    int model [64];
    logic [31:0] got_a [64];
    logic [31:0] got_b [64];
    int acc_cnt, tgt;

    always #5 clk = ~clk;

    gr_hist #(.P_CNT_W(16)) dut_a (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .start(start), .nsamp(nsamp),
        .busy(busy_a), .done(done_a), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a)
    );

    gr_hist #(.P_CNT_W(4)) dut_b (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .start(start), .nsamp(nsamp),
        .busy(busy_b), .done(done_b), .rd_req(rd_req), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int ref_bin(input logic [11:0] d);
        int q;
        q = int'(d) / 64;
        return (q > 63) ? 63 : q;
    endfunction

    function automatic int sat(input int c, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (c > mx) ? mx : c;
    endfunction

    task automatic model_clear();
        for (int b = 0; b < 64; b++) model[b] = 0;
        acc_cnt = 0;
    endtask

    // Drive one cycle of input; the model counts it if acquisition still needs samples.
    task automatic send(input logic [11:0] d, input logic v);
        din = d;
        din_valid = v;
        if (v && acc_cnt < tgt) begin
            model[ref_bin(d)]++;
            acc_cnt++;
        end
        tick();
    endtask

    // Pulse start; returns in the first ACC cycle (or DONE for n=0), counting busy cycles.
    task automatic do_start(input int n, input string tag);
        int bc;
        tgt = n;
        model_clear();
        start = 1'b1;
        nsamp = 20'(n);
        tick();
        start = 1'b0;
        bc = 0;
        for (int k = 0; k < 64; k++) begin
            if (busy_a) bc++;
            tick();
        end
        chk({tag, "_clear_busy_cycles"}, bc, 64);
    endtask

    task automatic wait_done(input int bound);
        din_valid = 1'b0;
        for (int i = 0; i < bound && !done_a; i++) tick();
        chk("done_reached", {31'd0, done_a}, 1);
        chk("done_b_reached", {31'd0, done_b}, 1);
    endtask

    task automatic read_all();
        int bad;
        bad = 0;
        for (int i = 0; i <= 64; i++) begin
            rd_req = (i < 64);
            rd_addr = 6'(i);
            tick();
            if (rd_valid_a !== (i >= 1) || rd_valid_b !== (i >= 1)) bad++;
            if (i >= 1) begin
                got_a[i-1] = {16'd0, rd_data_a};
                got_b[i-1] = {28'd0, rd_data_b};
            end
        end
        rd_req = 1'b0;
        chk("rd_pipe_valid", bad, 0);
        tick();
        chk("rd_idle_valid", {31'd0, rd_valid_a}, 0);
        chk("rd_data_hold", {16'd0, rd_data_a}, got_a[63]);
    endtask

    task automatic cmp_model(input string tag);
        for (int b = 0; b < 64; b++) begin
            chk($sformatf("%s_bin%0d_w16", tag, b), got_a[b], sat(model[b], 16));
            chk($sformatf("%s_bin%0d_w4", tag, b), got_b[b], sat(model[b], 4));
        end
    endtask

    initial begin
        stim_t stim [10];
        exp_t  expv [5];
        int    bad_rv, sum, jlast, kdone, n;
        logic [11:0] d;
        logic  v;

        stim = '{'{12'h000, 1'b1}, '{12'h000, 1'b0}, '{12'h000, 1'b1}, '{12'h040, 1'b1},
                 '{12'h7FF, 1'b0}, '{12'h7FF, 1'b0}, '{12'h000, 1'b1}, '{12'h040, 1'b1},
                 '{12'h123, 1'b0}, '{12'hFFF, 1'b1}};
        expv = '{'{6'd0, 16'd3}, '{6'd1, 16'd2}, '{6'd63, 16'd1}, '{6'd2, 16'd0}, '{6'd62, 16'd0}};

        rst = 1'b1; din = '0; din_valid = 1'b0; start = 1'b0; nsamp = '0;
        rd_req = 1'b0; rd_addr = '0; tgt = 0;
        model_clear();
        tick();
        tick();
        chk("rst_busy", {31'd0, busy_a | busy_b}, 0);
        chk("rst_done", {31'd0, done_a | done_b}, 0);
        chk("rst_rd_valid", {31'd0, rd_valid_a | rd_valid_b}, 0);
        chk("rst_rd_data_a", {16'd0, rd_data_a}, 0);
        chk("rst_rd_data_b", {28'd0, rd_data_b}, 0);
        rst = 1'b0;
        tick();

        // Same-bin stress with ignored start and ignored read during ACC
        do_start(1000, "stress");
        bad_rv = 0;
        for (int i = 0; i < 1000; i++) begin
            start = (i == 300);
            if (i == 300) nsamp = 20'd5;
            rd_req = (i == 500);
            rd_addr = 6'd5;
            send(12'h140, 1'b1);
            if (rd_valid_a || rd_valid_b) bad_rv++;
        end
        start = 1'b0; rd_req = 1'b0;
        chk("stress_done_lat1", {31'd0, done_a}, 0);
        chk("stress_busy_lat1", {31'd0, busy_a}, 1);
        tick();
        chk("stress_done_lat2", {31'd0, done_a}, 0);
        tick();
        chk("stress_done_lat3", {31'd0, done_a}, 1);
        chk("stress_busy_lat3", {31'd0, busy_a}, 0);
        chk("acc_rd_valid_seen", bad_rv, 0);
        // samples in DONE must be dropped
        for (int i = 0; i < 10; i++) tick();
        din_valid = 1'b0;
        read_all();
        cmp_model("stress");

        // Clear with nsamp=0, plus a read in flight across start
        start = 1'b1; nsamp = 20'd0; rd_req = 1'b1; rd_addr = 6'd5;
        tgt = 0;
        tick();
        start = 1'b0; rd_req = 1'b0;
        sum = busy_a ? 1 : 0;
        chk("inflight_rv_early", {31'd0, rd_valid_a}, 0);
        tick();
        sum += busy_a ? 1 : 0;
        chk("inflight_rv", {31'd0, rd_valid_a & rd_valid_b}, 1);
        chk("inflight_data_a", {16'd0, rd_data_a}, 1000);
        chk("inflight_data_b", {28'd0, rd_data_b}, 15);
        for (int k = 0; k < 62; k++) begin
            tick();
            sum += busy_a ? 1 : 0;
        end
        tick();
        chk("clear_busy_cycles", sum, 64);
        chk("clear_busy_end", {31'd0, busy_a}, 0);
        chk("clear_done", {31'd0, done_a}, 1);
        model_clear();
        read_all();
        cmp_model("clear");

        // Interleaved bins from the vector table
        do_start(6, "inter");
        for (int i = 0; i < 10; i++) send(stim[i].din, stim[i].vld);
        wait_done(20);
        read_all();
        for (int i = 0; i < 5; i++)
            chk($sformatf("inter_tbl_bin%0d", expv[i].addr), got_a[expv[i].addr], {16'd0, expv[i].cnt});
        cmp_model("inter");

        // Saturation: 20 samples into bin 2
        do_start(20, "sat");
        for (int i = 0; i < 20; i++) send(12'h080, 1'b1);
        wait_done(20);
        read_all();
        chk("sat_bin2_w16", got_a[2], 20);
        chk("sat_bin2_w4", got_b[2], 15);
        cmp_model("sat");

        // Reset mid-ACC, then a fresh run of 10
        do_start(100, "rstacc");
        for (int i = 0; i < 50; i++) send(12'h3C0, 1'b1);
        din_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("rstacc_busy", {31'd0, busy_a | busy_b}, 0);
        chk("rstacc_done", {31'd0, done_a | done_b}, 0);
        chk("rstacc_rd_valid", {31'd0, rd_valid_a | rd_valid_b}, 0);
        tick();
        rst = 1'b0;
        tick();
        do_start(10, "post_rst");
        for (int i = 0; i < 10; i++) send(12'($urandom), 1'b1);
        wait_done(20);
        read_all();
        sum = 0;
        for (int b = 0; b < 64; b++) sum += int'(got_a[b]);
        chk("post_rst_total", sum, 10);
        cmp_model("post_rst");

        // Randomized runs against the reference model
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(150, 400);
            do_start(n, "rand");
            jlast = -1;
            kdone = -1;
            for (int it = 0; it < 3000; it++) begin
                if ($urandom_range(0, 1) == 1)
                    d = 12'($urandom_range(0, 3) * 64 + $urandom_range(0, 63));
                else
                    d = 12'($urandom);
                v = ($urandom_range(0, 3) != 0);
                if (v && acc_cnt == tgt - 1) jlast = it;
                send(d, v);
                if (done_a && kdone < 0) kdone = it;
                if (kdone >= 0 && it >= kdone + 5) break;
            end
            din_valid = 1'b0;
            chk($sformatf("rand%0d_done_seen", r), {31'd0, done_a & done_b}, 1);
            chk($sformatf("rand%0d_done_latency", r), kdone - jlast, 2);
            read_all();
            cmp_model($sformatf("rand%0d", r));
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
